// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic matrix-multiply engine.
// The product helper widens operands to 64 bits so PE accumulators can take any width up to 64.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int PROD_W = 64;

  function automatic int cnt_w(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  localparam int N_DEFAULT       = 4;
  localparam int K_MAX_DEFAULT   = 256;
  localparam int K_LEN_W_DEFAULT = cnt_w(K_MAX_DEFAULT + 1);
  localparam int ROW_W_DEFAULT   = cnt_w(N_DEFAULT);

  // Full-width product of two dw-bit operands, sign- or zero-extended first.
  function automatic logic [PROD_W-1:0] mul_ext(input logic [31:0] a, input logic [31:0] b,
                                                input int dw, input logic sgn);
    logic [PROD_W-1:0] ax;
    logic [PROD_W-1:0] bx;
    int                sh;
    sh = PROD_W - dw;
    ax = {32'd0, a} << sh;
    bx = {32'd0, b} << sh;
    if (sgn) begin
      ax = $signed(ax) >>> sh;
      bx = $signed(bx) >>> sh;
    end else begin
      ax = ax >> sh;
      bx = bx >> sh;
    end
    return ax * bx;
  endfunction

endpackage

// File: rtl/systolic_mm_engine_pe.sv
// One processing element: multiply-accumulate with registered a/b forwarding.
// clr wins over en so a new job starts from a clean array.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;

  // MAC and forwarding next-state.
  always_comb begin
    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    if (clr) begin
      acc_d = {ACC_WIDTH{1'b0}};
      a_d   = {DATA_WIDTH{1'b0}};
      b_d   = {DATA_WIDTH{1'b0}};
    end else if (en) begin
      acc_d = acc_q + ACC_WIDTH'(mul_ext(32'(a_in), 32'(b_in), DATA_WIDTH, (SIGNED != 0)));
      a_d   = a_in;
      b_d   = b_in;
    end else begin
      acc_d = acc_q;
    end
  end

  // PE state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {ACC_WIDTH{1'b0}};
      a_q   <= {DATA_WIDTH{1'b0}};
      b_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// Self-sequencing N x N output-stationary systolic matrix multiply: load K beats,
// flush 2N-2 cycles with zeros, then drain C one row per handshake.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_MAX      = 256,
  parameter int SIGNED     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  output logic                         busy,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*DATA_WIDTH-1:0]      in_a,
  input  logic [N*DATA_WIDTH-1:0]      in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N*ACC_WIDTH-1:0]       out_row,
  output logic [$clog2(N)-1:0]         out_row_idx,
  output logic                         done
);

  localparam int KW         = $clog2(K_MAX + 1);
  localparam int RW         = $clog2(N);
  localparam int FW         = cnt_w(2 * N - 2);
  localparam int FLUSH_LAST = 2 * N - 3;
  localparam int DW         = DATA_WIDTH;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d, beat_q, beat_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic [RW-1:0]   row_q, row_d;
  logic            busy_q, in_ready_q, out_valid_q, done_q, done_d;
  logic            adv_s, clr_s;

  logic [DW-1:0]        a_lane_s [N];
  logic [DW-1:0]        b_lane_s [N];
  logic [DW-1:0]        a_sk_q [N][N];
  logic [DW-1:0]        a_sk_d [N][N];
  logic [DW-1:0]        b_sk_q [N][N];
  logic [DW-1:0]        b_sk_d [N][N];
  logic [DW-1:0]        a_h [N][N+1];
  logic [DW-1:0]        b_v [N+1][N];
  logic [ACC_WIDTH-1:0] acc_s [N][N];

  assign adv_s = ((state_q == LOAD) && in_valid) || (state_q == FLUSH);
  assign clr_s = (state_q == IDLE) && start;

  // Sequencer next-state.
  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_len_d = k_len;
          beat_d  = KW'(0);
          flush_d = FW'(0);
          row_d   = RW'(0);
          if (k_len == KW'(0)) begin
            state_d = DRAIN;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          beat_d = beat_q + KW'(1);
          if (beat_q == k_len_q - KW'(1)) begin
            state_d = FLUSH;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      FLUSH: begin
        if (flush_q == FW'(FLUSH_LAST)) begin
          state_d = DRAIN;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (row_q == RW'(N - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers with outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_len_q     <= KW'(0);
      beat_q      <= KW'(0);
      flush_q     <= FW'(0);
      row_q       <= RW'(0);
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_q      <= beat_d;
      flush_q     <= flush_d;
      row_q       <= row_d;
      busy_q      <= (state_d != IDLE);
      in_ready_q  <= (state_d == LOAD);
      out_valid_q <= (state_d == DRAIN);
      done_q      <= done_d;
    end
  end

  // Operand lanes; zeros outside LOAD give the flush injection.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (state_q == LOAD) begin
        a_lane_s[i] = in_a[i*DW +: DW];
        b_lane_s[i] = in_b[i*DW +: DW];
      end else begin
        a_lane_s[i] = {DW{1'b0}};
        b_lane_s[i] = {DW{1'b0}};
      end
    end
  end

  // Skew shift chains; lane i uses stages 0..i-1.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (clr_s) begin
        a_sk_d[i][0] = {DW{1'b0}};
        b_sk_d[i][0] = {DW{1'b0}};
      end else if (adv_s) begin
        a_sk_d[i][0] = a_lane_s[i];
        b_sk_d[i][0] = b_lane_s[i];
      end else begin
        a_sk_d[i][0] = a_sk_q[i][0];
        b_sk_d[i][0] = b_sk_q[i][0];
      end
      for (int s = 1; s < N; s++) begin
        if (clr_s) begin
          a_sk_d[i][s] = {DW{1'b0}};
          b_sk_d[i][s] = {DW{1'b0}};
        end else if (adv_s) begin
          a_sk_d[i][s] = a_sk_q[i][s-1];
          b_sk_d[i][s] = b_sk_q[i][s-1];
        end else begin
          a_sk_d[i][s] = a_sk_q[i][s];
          b_sk_d[i][s] = b_sk_q[i][s];
        end
      end
    end
  end

  // Skew chain registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int s = 0; s < N; s++) begin
          a_sk_q[i][s] <= {DW{1'b0}};
          b_sk_q[i][s] <= {DW{1'b0}};
        end
      end
    end else begin
      a_sk_q <= a_sk_d;
      b_sk_q <= b_sk_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_entry
    if (i == 0) begin : g_direct
      assign a_h[0][0] = a_lane_s[0];
      assign b_v[0][0] = b_lane_s[0];
    end else begin : g_skewed
      assign a_h[i][0] = a_sk_q[i][i-1];
      assign b_v[0][i] = b_sk_q[i][i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED     (SIGNED)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_s),
        .en    (adv_s),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (acc_s[i][j])
      );
    end
  end

  // Result row select; accumulators are frozen during DRAIN so the row holds under stall.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_s[row_q][j];
    end
  end

  assign busy        = busy_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;
  assign out_row_idx = row_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed and randomised jobs for systolic_mm_engine (N=3, signed 8-bit operands),
// checked against a plain sum-of-products reference.
module tb_systolic_mm_engine;

  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int KMAX = 256;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int RW   = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_a;
  logic [N*DW-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [N*AW-1:0] out_row;
  logic [RW-1:0]   out_row_idx;
  logic            done;

  always #5 clk = ~clk;

  systolic_mm_engine #(
    .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KMAX), .SIGNED(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int am [N][KMAX];
  int bm [KMAX][N];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*AW-1:0] ref_row(input int r, input int k);
    logic [N*AW-1:0] v;
    longint          s;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int kk = 0; kk < k; kk++) s += longint'(am[r][kk]) * longint'(bm[kk][j]);
      v[j*AW +: AW] = s[AW-1:0];
    end
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int k);
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++) begin
        am[i][kk] = int'($urandom_range(255, 0)) - 128;
        bm[kk][i] = int'($urandom_range(255, 0)) - 128;
      end
  endtask

  task automatic fill_seq_b;
    for (int kk = 0; kk < N; kk++)
      for (int j = 0; j < N; j++) bm[kk][j] = N * kk + j + 1;
  endtask

  task automatic feed(input int k, input int bubble_pct, output int idx);
    int   guard;
    logic acc_beat;
    idx   = 0;
    guard = 0;
    while (idx < k && guard < 4 * k + 100) begin
      if (int'($urandom_range(99, 0)) < bubble_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
          in_a[i*DW +: DW] = DW'(am[i][idx]);
          in_b[i*DW +: DW] = DW'(bm[idx][i]);
        end
      end
      acc_beat = in_valid && in_ready;
      tick;
      guard++;
      if (acc_beat) idx++;
    end
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic run_job(input string tag, input int k, input int bubble_pct, input int stall_row,
                         input int stall_cyc, input int oready_pct, input bit poke_start);
    int              idx, guard, r, lat, stall_left;
    logic            acc_row;
    logic [N*AW-1:0] exp;
    start = 1'b1;
    k_len = KW'(k);
    tick;
    start = 1'b0;
    chk({tag, " busy"}, busy, 1'b1);
    chk({tag, " in_ready"}, in_ready, (k > 0));
    feed(k, bubble_pct, idx);
    chk({tag, " beats"}, idx, k);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick;
      lat++;
    end
    chk({tag, " flush_len"}, lat, (k > 0) ? 2 * N - 2 : 0);
    r          = 0;
    guard      = 0;
    stall_left = stall_cyc;
    while (r < N && guard < 200) begin
      exp = ref_row(r, k);
      chk({tag, " out_valid"}, out_valid, 1'b1);
      chk({tag, " row_idx"}, out_row_idx, r);
      chk({tag, " row"}, out_row, exp);
      if (r == stall_row && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = (int'($urandom_range(99, 0)) < oready_pct);
      end
      if (poke_start && guard == 0) begin
        start = 1'b1;
        k_len = KW'(5);
      end else begin
        start = 1'b0;
      end
      acc_row = out_ready;
      tick;
      start = 1'b0;
      guard++;
      if (acc_row) r++;
    end
    out_ready = 1'b0;
    chk({tag, " rows_drained"}, r, N);
    chk({tag, " done_pulse"}, done, 1'b1);
    chk({tag, " out_valid_drop"}, out_valid, 1'b0);
    chk({tag, " idle"}, {busy, in_ready}, 2'b00);
    tick;
    chk({tag, " done_single"}, done, 1'b0);
  endtask

  initial begin
    int idx;
    rst = 1'b1; start = 1'b1; k_len = KW'(3);
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    // Reset held with start asserted.
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("reset_ctrl", {busy, in_ready, out_valid, done}, 4'b0000);
      chk("reset_row", {out_row, out_row_idx}, '0);
    end
    start = 1'b0;
    rst   = 1'b0;
    tick;
    chk("post_reset_idle", busy, 1'b0);

    // A = B = [[1,2,3],[4,5,6],[7,8,9]].
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < N; kk++) am[i][kk] = N * i + kk + 1;
    fill_seq_b;
    run_job("mat9", 3, 0, -1, 0, 100, 1'b0);
    run_job("mat9_bubbles", 3, 40, 1, 5, 100, 1'b0);

    // A = -I against extreme signed operands.
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < N; kk++) am[i][kk] = (i == kk) ? -1 : 0;
    bm[0][0] = 127; bm[0][1] = -128; bm[0][2] = 5;
    bm[1][0] = 0;   bm[1][1] = 1;    bm[1][2] = -1;
    bm[2][0] = -7;  bm[2][1] = 3;    bm[2][2] = 2;
    run_job("neg_identity", 3, 0, -1, 0, 100, 1'b0);

    run_job("k_zero", 0, 0, -1, 0, 100, 1'b1);

    // Abort mid-FLUSH, then an identity job must return B exactly.
    fill_random(3);
    start = 1'b1; k_len = KW'(3);
    tick;
    start = 1'b0;
    feed(3, 0, idx);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_ctrl", {busy, in_ready, out_valid, done}, 4'b0000);
    chk("abort_row", out_row, '0);
    tick;
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < N; kk++) am[i][kk] = (i == kk) ? 1 : 0;
    fill_seq_b;
    run_job("after_abort", 3, 0, -1, 0, 100, 1'b0);

    run_job_random_set();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic run_job_random_set;
    int k;
    fill_random(1);
    run_job("k_one", 1, 0, -1, 0, 100, 1'b0);
    for (int t = 0; t < 6; t++) begin
      k = int'($urandom_range(12, 1));
      fill_random(k);
      run_job("random", k, 30, int'($urandom_range(N - 1, 0)), 2, 70, 1'b0);
    end
    for (int kk = 0; kk < KMAX; kk++)
      for (int i = 0; i < N; i++) begin
        am[i][kk] = -128;
        bm[kk][i] = (i == 1) ? 127 : -128;
      end
    run_job("k_max", KMAX, 10, -1, 0, 100, 1'b0);
  endtask

endmodule
